retro_memory_copy: RTL

- Block-copy/fill engine acting as the Initiator on a RetroMemoryPort. It is the requesting end of the port that RetroSRAM serves as Target.
- Given a source address, destination address and word count, it moves data word by word (copy) or writes a constant (fill).
- Used for VRAM clears, sprite/tile uploads and work-RAM initialisation.
- Instantiated beside the CPU, with its port muxed or arbitrated onto the shared memory bus.

---
 rtl/retro_memory_pkg.sv | 26 ++
 rtl/retro_memory_copy.sv | 117 +++++++++++
 2 files changed

// File: rtl/retro_memory_pkg.sv
// Shared types for the retro memory block-copy/fill engine.
// Widths here are the defaults used by retro_memory_copy.
package retro_memory_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned DataWidth = 8;
  localparam int unsigned LenWidth  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReadReq,
    StReadWait,
    StWriteReq,
    StFinish
  } state_e;

  // Latched command; src/dst/length double as the running counters.
  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  length;
    logic                 fill;
    logic [DataWidth-1:0] data;
  } cmd_t;

endpackage

// File: rtl/retro_memory_copy.sv
// Block-copy/fill engine: initiator side of the retro memory port.
// Moves words src->dst (copy) or writes a constant (fill), one request at a time.
module retro_memory_copy
  import retro_memory_pkg::*;
#(
  parameter int unsigned AddressBusWidth = AddrWidth,
  parameter int unsigned DataBusWidth    = DataWidth,
  parameter int unsigned LengthWidth     = LenWidth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       fill,
  input  logic [AddressBusWidth-1:0] src_address,
  input  logic [AddressBusWidth-1:0] dst_address,
  input  logic [LengthWidth-1:0]     length,
  input  logic [DataBusWidth-1:0]    fill_data,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_access,
  output logic                       mem_write,
  output logic [AddressBusWidth-1:0] mem_address,
  output logic [DataBusWidth-1:0]    mem_din,
  input  logic [DataBusWidth-1:0]    mem_dout,
  input  logic                       mem_ready,
  input  logic                       mem_data_ready
);

  state_e                     state_q, state_d;
  cmd_t                       cmd_q, cmd_d;
  logic [DataBusWidth-1:0]    buf_q, buf_d;
  logic                       access_d, write_d;
  logic [AddressBusWidth-1:0] address_d;
  logic [DataBusWidth-1:0]    din_d;
  logic                       accept;

  assign accept = mem_access & mem_ready;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cmd_d = '{src: src_address, dst: dst_address, length: length,
                    fill: fill, data: fill_data};
          if (length == '0) begin
            state_d = StFinish;
          end else if (fill) begin
            state_d = StWriteReq;
          end else begin
            state_d = StReadReq;
          end
        end
      end
      StReadReq: begin
        if (accept) state_d = StReadWait;
      end
      StReadWait: begin
        if (mem_data_ready) begin
          buf_d   = mem_dout;
          state_d = StWriteReq;
        end
      end
      StWriteReq: begin
        if (accept) begin
          cmd_d.src    = cmd_q.src + AddrWidth'(1);
          cmd_d.dst    = cmd_q.dst + AddrWidth'(1);
          cmd_d.length = cmd_q.length - LenWidth'(1);
          if (cmd_q.length == LenWidth'(1)) begin
            state_d = StFinish;
          end else if (!cmd_q.fill) begin
            state_d = StReadReq;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Port outputs are registered, so they are derived from the next state;
  // an unaccepted request recomputes identical values and thus holds.
  always_comb begin
    access_d  = (state_d == StReadReq) || (state_d == StReadWait) || (state_d == StWriteReq);
    write_d   = (state_d == StWriteReq);
    address_d = '0;
    din_d     = '0;
    if (access_d) address_d = write_d ? cmd_d.dst : cmd_d.src;
    if (write_d)  din_d = cmd_d.fill ? cmd_d.data : buf_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      buf_q       <= '0;
      mem_access  <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_din     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      buf_q       <= buf_d;
      mem_access  <= access_d;
      mem_write   <= write_d;
      mem_address <= address_d;
      mem_din     <= din_d;
    end
  end

  assign busy = (state_q == StReadReq) || (state_q == StReadWait) || (state_q == StWriteReq);
  assign done = (state_q == StFinish);

endmodule
